// File: rtl/fractal_pkg.sv
// Shared constants, payload type, state encoding and pixel helpers for the
// fractal renderer's framebuffer write path.
package fractal_pkg;

  localparam int unsigned SCREEN_W   = 160;
  localparam int unsigned SCREEN_H   = 120;
  localparam int unsigned FB_WORDS   = 19200;

  localparam int unsigned X_W        = 8;
  localparam int unsigned Y_W        = 7;
  localparam int unsigned ITER_W     = 8;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned COL_W      = 3;
  localparam int unsigned DROP_W     = 8;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 3;

  // One queued framebuffer write (18 bits)
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  colour;
  } pixel_t;

  localparam int unsigned FIFO_W = $bits(pixel_t);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    CLEAR      = 2'd1,
    CLEAR_WAIT = 2'd2
  } wr_state_t;

  // y*160 + x built from two shifts; fits in 15 bits for on-screen pixels
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
  endfunction

  // Points inside the set are black; a low-bit value of zero maps to white
  function automatic logic [COL_W-1:0] pixel_colour(input logic [ITER_W-1:0] iter,
                                                    input logic [ITER_W-1:0] max_iter);
    if (iter >= max_iter)
      return '0;
    else if (iter[COL_W-1:0] == '0)
      return '1;
    else
      return iter[COL_W-1:0];
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: 4-entry first-word-fall-through queue of pixel writes.
//   clk, rst     clock, async active-low reset
//   push, din    write strobe and payload (accepted when not full, or when
//                full with a simultaneous pop)
//   pop          remove head (ignored when empty)
//   head_c       current head entry (combinational read of storage)
//   full, empty  registered status flags
//   count        registered occupancy 0..4
module pixel_fifo
  import fractal_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  pixel_t           din,
  input  logic             pop,
  output pixel_t           head_c,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  pixel_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_nx;

  // A pop frees the slot being written when full, so both may proceed
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign count_nx = count + CNT_W'(do_push) - CNT_W'(do_pop);
  assign head_c   = mem[rd_ptr];

  // Storage, pointers and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nx;
      full  <= (count_nx == CNT_W'(FIFO_DEPTH));
      empty <= (count_nx == '0);
    end
  end

endmodule

// File: rtl/pixel_writer.sv
// pixel_writer: queues pixel plots from the fractal controller and drives
// them into the framebuffer over a wr_en/wr_ready handshake; can also blank
// the whole frame.
//   clk, rst             clock, async active-low reset
//   plot, x_in, y_in     pixel request and coordinates
//   iter_in, max_iter    escape count and limit (colour selection)
//   clear                request to blank the frame
//   stall                backpressure (queue nearly full or clearing)
//   wr_en, wr_addr,
//   wr_colour, wr_ready  framebuffer write handshake
//   overflow             sticky: a plot was lost to a full queue
//   dropped              saturating count of rejected plots
//   idle                 nothing queued, nothing pending, running
module pixel_writer
  import fractal_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              plot,
  input  logic [X_W-1:0]    x_in,
  input  logic [Y_W-1:0]    y_in,
  input  logic [ITER_W-1:0] iter_in,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              clear,
  output logic              stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [COL_W-1:0]  wr_colour,
  input  logic              wr_ready,
  output logic              overflow,
  output logic [DROP_W-1:0] dropped,
  output logic              idle
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  wr_state_t         state;
  wr_state_t         state_nx;
  logic              clear_req;
  logic              clear_req_nx;
  logic              wr_en_nx;
  logic [ADDR_W-1:0] wr_addr_nx;
  logic [COL_W-1:0]  wr_colour_nx;
  logic              stall_nx;
  logic              idle_nx;
  logic              overflow_nx;
  logic [DROP_W-1:0] dropped_nx;

  logic              in_range_c;
  logic              push_c;
  logic              pop_c;
  logic              full_drop_c;
  pixel_t            push_data_c;
  logic [CNT_W-1:0]  count_nx_c;

  pixel_t            head_c;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // The queue entry stays resident until the framebuffer accepts it, so the
  // pending write is part of the occupancy that drives stall and overflow.
  pixel_fifo u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_c),
    .din    (push_data_c),
    .pop    (pop_c),
    .head_c (head_c),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Push/pop qualification and payload formation
  always_comb begin
    in_range_c         = (x_in < X_W'(SCREEN_W)) && (y_in < Y_W'(SCREEN_H));
    pop_c              = (state == RUN) && wr_en && wr_ready;
    push_c             = plot && in_range_c && (!fifo_full || pop_c);
    full_drop_c        = plot && in_range_c && fifo_full && !pop_c;
    push_data_c        = '0;
    push_data_c.addr   = pixel_addr(x_in, y_in);
    push_data_c.colour = pixel_colour(iter_in, max_iter);
    count_nx_c         = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Next-state and output-register logic
  always_comb begin
    state_nx     = state;
    clear_req_nx = clear_req;
    wr_en_nx     = wr_en;
    wr_addr_nx   = wr_addr;
    wr_colour_nx = wr_colour;

    unique case (state)
      RUN: begin
        if (wr_en && wr_ready) wr_en_nx = 1'b0;
        if (!wr_en && (clear || clear_req)) begin
          // First blanking write is presented on the transition edge
          state_nx     = CLEAR;
          clear_req_nx = 1'b0;
          wr_en_nx     = 1'b1;
          wr_addr_nx   = '0;
          wr_colour_nx = '0;
        end else begin
          if (clear) clear_req_nx = 1'b1;
          if (!wr_en && !fifo_empty) begin
            wr_en_nx     = 1'b1;
            wr_addr_nx   = head_c.addr;
            wr_colour_nx = head_c.colour;
          end
        end
      end
      CLEAR: begin
        // Back-to-back blanking writes; wr_addr doubles as the sweep counter
        if (wr_en && wr_ready) begin
          if (wr_addr == LAST_ADDR) begin
            wr_en_nx = 1'b0;
            state_nx = CLEAR_WAIT;
          end else begin
            wr_addr_nx = wr_addr + ADDR_W'(1);
          end
        end
      end
      CLEAR_WAIT: begin
        state_nx = RUN;
        if (clear) clear_req_nx = 1'b1;
      end
      default: begin
        state_nx = RUN;
        wr_en_nx = 1'b0;
      end
    endcase

    overflow_nx = overflow || full_drop_c;
    dropped_nx  = dropped;
    if (plot && (!in_range_c || full_drop_c) && (dropped != '1))
      dropped_nx = dropped + DROP_W'(1);

    stall_nx = (count_nx_c >= CNT_W'(3)) || (state_nx == CLEAR);
    idle_nx  = (count_nx_c == '0) && !wr_en_nx && (state_nx == RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      clear_req <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_colour <= '0;
      overflow  <= 1'b0;
      dropped   <= '0;
      stall     <= 1'b0;
      idle      <= 1'b1;
    end else begin
      state     <= state_nx;
      clear_req <= clear_req_nx;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      wr_colour <= wr_colour_nx;
      overflow  <= overflow_nx;
      dropped   <= dropped_nx;
      stall     <= stall_nx;
      idle      <= idle_nx;
    end
  end

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 plot  input  1  pixel request strobe from the fractal controller; one pixel per high cycle.
REQ-004 x_in  input  8  pixel column, valid range 0..159.
REQ-005 y_in  input  7  pixel row, valid range 0..119.
REQ-006 iter_in  input  8  escape iteration count for the pixel.
REQ-007 max_iter  input  8  iteration limit; quasi-static while plot traffic is active.
REQ-008 clear  input  1  one-cycle request to blank the whole frame.
REQ-009 stall  output  1  backpressure to the controller; asserted when FIFO count >= 3 or state is CLEAR.
REQ-010 wr_en  output  1  framebuffer write request.
REQ-011 wr_addr  output  15  framebuffer address = y*160 + x.
REQ-012 wr_colour  output  3  framebuffer colour.
REQ-013 wr_ready  input  1  framebuffer accepts the current write at a rising edge where wr_en && wr_ready.
REQ-014 overflow  output  1  sticky; set when a plot arrives with FIFO full and no pop in the same cycle.
REQ-015 dropped  output  8  count of out-of-range or overflowed plots; saturates at 255.
REQ-016 idle  output  1  high when the FIFO is empty, no write is pending, and state is RUN.

Function
REQ-017 Plot requests SHALL enter a 4-entry FIFO of {addr[14:0], colour[2:0]}; address and colour are computed combinationally at push.
REQ-018 Colour SHALL be 3'b000 when iter_in >= max_iter; otherwise iter_in[2:0], except that a value of 0 SHALL map to 3'b111.
REQ-019 Address SHALL be computed as (y<<7)+(y<<5)+x in 15 bits without a multiplier; max 19199.
REQ-020 Plots with x_in >= 160 or y_in >= 120 SHALL NOT be pushed and SHALL increment dropped.
REQ-021 Plots arriving while the FIFO is full with no simultaneous pop SHALL be discarded, SHALL set overflow, and SHALL increment dropped; push and pop in the same cycle when full SHALL succeed.
REQ-022 The output stage SHALL load the FIFO head into the wr_* registers when no write is pending; wr_en rises at the earliest one cycle after the push edge.
REQ-023 wr_addr and wr_colour SHALL hold stable while wr_en is high and wr_ready is low.
REQ-024 After an accepted write, the next FIFO entry SHALL present in the following cycle; sustained throughput is one write every 2 cycles.
REQ-025 The FSM SHALL have the states RUN, CLEAR, and CLEAR_WAIT.
REQ-026 RUN SHALL transition to CLEAR on clear only when no write is pending; otherwise the clear request SHALL be latched and taken after the pending write completes.
REQ-027 CLEAR SHALL issue writes with colour 000 to addresses 0..19199 in ascending order using the same wr_en/wr_ready handshake.
REQ-028 CLEAR SHALL transition to CLEAR_WAIT after the write to address 19199 is accepted.
REQ-029 CLEAR_WAIT SHALL transition to RUN after one cycle.
REQ-030 FIFO pushes SHALL continue during CLEAR; pops SHALL be suspended during CLEAR.
REQ-031 A clear asserted during CLEAR SHALL be ignored.

Reset
REQ-032 While rst is low: state = RUN, FIFO empty, wr_en = 0, wr_addr = 0, wr_colour = 0, overflow = 0, dropped = 0, stall = 0, idle = 1.
REQ-033 Reset asserted mid-write or mid-clear SHALL abandon the operation immediately, with no partial transfer retained.

Structure
REQ-034 The constants SCREEN_W = 160, SCREEN_H = 120, FB_WORDS = 19200, and the state enum type SHALL reside in the shared package fractal_pkg.
REQ-035 The FIFO SHALL be a separate sub-module, pixel_fifo (depth 4, width 18, full/empty/count outputs).

Verification
REQ-036 Single plot: x=5, y=2, iter=3, max=16, wr_ready=1 -> exactly one write with addr=325, colour=3, with wr_en rising one cycle after the push.
REQ-037 Colour map: iter=16, max=16 -> colour 0; iter=8 -> colour 7; iter=13 -> colour 5.
REQ-038 Backpressure: wr_ready=0 with 6 back-to-back plots -> stall high after the 3rd push, overflow set, dropped=2, and the 4 stored writes emerge in order once wr_ready=1.
REQ-039 Out-of-range: x=160, y=0 -> no write and dropped=1; x=159, y=119 -> addr 19199.
REQ-040 Clear: pulse clear with wr_ready=1 -> 19200 writes of colour 0 to addresses 0..19199 with stall high throughout, then idle=1; a plot pushed mid-clear is written after the clear completes.
REQ-041 Reset asserted mid-clear -> wr_en=0, dropped=0, and state RUN on the cycle after deassertion.
